icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped instruction cache between the instruction fetcher and the memory controller.
- It is the requesting end of the controller's ICache port: it raises ICMC_en/ICMC_addr on a miss and accepts the 64-bit block returned with MCIC_en.
- It serves fetcher lookups with one-cycle hit latency and refills one block per miss.

Parameters:
- BLOCK_WIDTH, 1, log2 of instructions per block (block = 8 bytes at default).
- BLOCK_SIZE, 1 << BLOCK_WIDTH, instructions per block.
- CACHE_WIDTH, 8, log2 of block count (index bits).
- BLOCK_NUM, 1 << CACHE_WIDTH, number of lines.
- ADDR_WIDTH, 32, address width.
- TAG_WIDTH, ADDR_WIDTH-CACHE_WIDTH-BLOCK_WIDTH-2, tag bits per line.

Ports:
- Sys_clk  in  1  clock.
- Sys_rst_n  in  1  asynchronous active-low reset.
- Sys_rdy  in  1  global enable; when 0 all state holds.
- IFIC_en  in  1  fetcher lookup request, level.
- IFIC_addr  in  ADDR_WIDTH  fetch PC, word aligned.
- ICIF_en  out  1  one-cycle response pulse.
- ICIF_inst  out  32  instruction for the request.
- ICMC_en  out  1  refill request to memory controller, level.
- ICMC_addr  out  ADDR_WIDTH  block-aligned refill address.
- MCIC_en  in  1  one-cycle refill-done pulse.
- MCIC_block  in  32*BLOCK_SIZE  refill data; bits [31:0] = instruction at block offset 0, little-endian bytes.

Behaviour:
- Address split (defaults): offset [2:0]; word select [2]; index [10:3]; tag [31:11].
- Storage per line: valid bit, tag, 64-bit data.
- Reset (async, Sys_rst_n=0):
  - all valid bits 0; state IDLE.
  - ICIF_en=0, ICIF_inst=0, ICMC_en=0, ICMC_addr=0.
  - Tag and data arrays need no reset.
- Sys_rdy=0: no register changes; outputs hold.
- States are IDLE and MISS.
- IDLE, ICIF_en=0, IFIC_en=1:
  - Hit (valid[index] and tag match): next edge ICIF_en<=1 and ICIF_inst<=selected word; stay IDLE.
  - Miss: next edge ICMC_en<=1, ICMC_addr<={IFIC_addr[31:3],3'b0}; miss address latched; go MISS; ICIF_en<=0.
- IDLE, ICIF_en=1 (cycle after a response):
  - ICIF_en<=0; IFIC_en is ignored this cycle.
  - Maximum throughput is therefore one response per 2 cycles.
- IDLE, IFIC_en=0: ICIF_en<=0.
- MISS:
  - ICMC_en and ICMC_addr stay stable until MCIC_en.
  - On MCIC_en=1, next edge:
    - line[index of miss addr] is written: data<=MCIC_block, tag, valid<=1.
    - ICMC_en<=0, ICMC_addr<=0, state<=IDLE.
    - If IFIC_en=1 and IFIC_addr equals the latched miss address: ICIF_en<=1 and ICIF_inst<=word selected from MCIC_block directly (no extra cycle).
    - Otherwise ICIF_en<=0.
- Abandoned request (IFIC_en dropped or address changed during MISS):
  - Refill still completes and is installed; no response is issued.
  - The next lookup starts from IDLE.
- Miss-to-response latency = controller refill time + 1 cycle. Hit latency = 1 cycle.
- MCIC_en in IDLE: ignored, no array write.
- ICMC_en deasserts on the same edge that MCIC_en is consumed, so the controller, which blocks re-entry while MCIC_en=1, never sees a duplicate request.
- Replacement overwrites unconditionally (direct-mapped); no dirty state.
- Reset asserted mid-MISS: request aborts immediately, all lines invalid; a late MCIC_en after reset is ignored.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined:
  - Adds outputs ICST_hit_cnt (32) and ICST_miss_cnt (32), both async-reset to 0.
  - hit_cnt increments per IDLE hit lookup; miss_cnt increments per IDLE→MISS transition.
  - Both counters wrap at 2^32 and hold when Sys_rdy=0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, IFIC_en=1, IFIC_addr=0x00001004.
  - Response: next edge ICMC_en=1, ICMC_addr=0x00001000.
  - Bench returns MCIC_block=0x22222222_11111111 with MCIC_en pulse; next edge ICIF_en=1, ICIF_inst=0x22222222, ICMC_en=0.
- Hit:
  - Stimulus: then IFIC_addr=0x00001000.
  - Response: ICIF_en=1 one cycle later, ICIF_inst=0x11111111, ICMC_en stays 0.
- Conflict:
  - Stimulus: IFIC_addr=0x00001800 (same index 0, different tag).
  - Response: miss, ICMC_addr=0x00001800; after refill, 0x00001000 misses again.
- Abort:
  - Stimulus: miss on 0x00000010, drop IFIC_en before MCIC_en.
  - Response: no ICIF_en pulse; a later request to 0x00000014 hits in 1 cycle.
- Stall/reset:
  - Stimulus 1: Sys_rdy=0 for 5 cycles during MISS.
  - Response 1: ICMC_en and ICMC_addr unchanged.
  - Stimulus 2: assert Sys_rst_n=0 mid-MISS.
  - Response 2: outputs 0 at once; a prior-hit address now misses.
- Stats (ICACHE_STATS_EN):
  - Stimulus: sequence above.
  - Response: ICST_hit_cnt=1 and ICST_miss_cnt=3 after the conflict test.

Source files
------------

// File: rtl/icache_direct_if.sv
// Fetcher/memory-controller bus seen by icache_direct. The cache is the slave side.
// The environment (fetcher plus memory controller) is the master side.
interface icache_direct_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 1
);
  logic                              IFIC_en;
  logic [ADDR_WIDTH-1:0]             IFIC_addr;
  logic                              ICIF_en;
  logic [31:0]                       ICIF_inst;
  logic                              ICMC_en;
  logic [ADDR_WIDTH-1:0]             ICMC_addr;
  logic                              MCIC_en;
  logic [32*(1 << BLOCK_WIDTH)-1:0]  MCIC_block;

  modport master (
    output IFIC_en, IFIC_addr, MCIC_en, MCIC_block,
    input  ICIF_en, ICIF_inst, ICMC_en, ICMC_addr
  );

  modport slave (
    input  IFIC_en, IFIC_addr, MCIC_en, MCIC_block,
    output ICIF_en, ICIF_inst, ICMC_en, ICMC_addr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: one-cycle hits, one block refilled per miss.
// Defining ICACHE_STATS_EN adds the ICST_hit_cnt / ICST_miss_cnt counters.
module icache_direct #(
  parameter int BLOCK_WIDTH = 1,
  parameter int CACHE_WIDTH = 8,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic        Sys_clk,
  input  logic        Sys_rst_n,
  input  logic        Sys_rdy,
`ifdef ICACHE_STATS_EN
  output logic [31:0] ICST_hit_cnt,
  output logic [31:0] ICST_miss_cnt,
`endif
  icache_direct_if.slave bus
);
  localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
  localparam int BLOCK_NUM  = 1 << CACHE_WIDTH;
  localparam int TAG_WIDTH  = ADDR_WIDTH - CACHE_WIDTH - BLOCK_WIDTH - 2;
  localparam int OFF_BITS   = BLOCK_WIDTH + 2;
  localparam int LINE_BITS  = 32 * BLOCK_SIZE;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                 state_q;
  logic [BLOCK_NUM-1:0]   valid_q;
  logic [ADDR_WIDTH-1:0]  miss_addr_q;
  logic [TAG_WIDTH-1:0]   tag_mem  [BLOCK_NUM];
  logic [LINE_BITS-1:0]   data_mem [BLOCK_NUM];

  logic [CACHE_WIDTH-1:0] req_idx, miss_idx;
  logic [TAG_WIDTH-1:0]   req_tag, miss_tag;
  logic [BLOCK_WIDTH-1:0] req_sel;
  logic                   req_hit, req_match;
  logic [31:0]            hit_word, fill_word;
  logic [ADDR_WIDTH-1:0]  blk_addr;

  assign req_idx   = bus.IFIC_addr[OFF_BITS +: CACHE_WIDTH];
  assign req_tag   = bus.IFIC_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_sel   = bus.IFIC_addr[2 +: BLOCK_WIDTH];
  assign miss_idx  = miss_addr_q[OFF_BITS +: CACHE_WIDTH];
  assign miss_tag  = miss_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign blk_addr  = {bus.IFIC_addr[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'(0)};

  assign req_hit   = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign req_match = (bus.IFIC_addr == miss_addr_q);
  assign hit_word  = data_mem[req_idx][{req_sel, 5'd0} +: 32];
  // A request still waiting on the refilled block is answered straight from the bus.
  assign fill_word = bus.MCIC_block[{req_sel, 5'd0} +: 32];

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      miss_addr_q   <= '0;
      bus.ICIF_en   <= 1'b0;
      bus.ICIF_inst <= '0;
      bus.ICMC_en   <= 1'b0;
      bus.ICMC_addr <= '0;
`ifdef ICACHE_STATS_EN
      ICST_hit_cnt  <= '0;
      ICST_miss_cnt <= '0;
`endif
    end else if (Sys_rdy) begin
      case (state_q)
        IDLE: begin
          bus.ICIF_en <= 1'b0;
          // The cycle after a response is dead so a held IFIC_en is not answered twice.
          if (bus.IFIC_en && !bus.ICIF_en) begin
            if (req_hit) begin
              bus.ICIF_en   <= 1'b1;
              bus.ICIF_inst <= hit_word;
`ifdef ICACHE_STATS_EN
              ICST_hit_cnt  <= ICST_hit_cnt + 32'd1;
`endif
            end else begin
              bus.ICMC_en   <= 1'b1;
              bus.ICMC_addr <= blk_addr;
              miss_addr_q   <= bus.IFIC_addr;
              state_q       <= MISS;
`ifdef ICACHE_STATS_EN
              ICST_miss_cnt <= ICST_miss_cnt + 32'd1;
`endif
            end
          end
        end
        MISS: begin
          if (bus.MCIC_en) begin
            valid_q[miss_idx] <= 1'b1;
            bus.ICMC_en       <= 1'b0;
            bus.ICMC_addr     <= '0;
            state_q           <= IDLE;
            if (bus.IFIC_en && req_match) begin
              bus.ICIF_en   <= 1'b1;
              bus.ICIF_inst <= fill_word;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays carry no reset; the cleared valid bits keep stale contents from hitting.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rdy && state_q == MISS && bus.MCIC_en) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= bus.MCIC_block;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Randomized self-checking bench for icache_direct against a block-address reference model.
// The bench plays fetcher and memory controller; define ICACHE_STATS_EN to also check counters.
module tb_icache_direct;
  logic Sys_clk   = 1'b0;
  logic Sys_rst_n = 1'b0;
  logic Sys_rdy   = 1'b1;

  always #5 Sys_clk = ~Sys_clk;

  icache_direct_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_direct dut (
    .Sys_clk      (Sys_clk),
    .Sys_rst_n    (Sys_rst_n),
    .Sys_rdy      (Sys_rdy),
`ifdef ICACHE_STATS_EN
    .ICST_hit_cnt (hit_cnt),
    .ICST_miss_cnt(miss_cnt),
`endif
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: which block address lives at each index, plus backing memory contents.
  logic [31:0] resident [int];
  logic [63:0] mem      [int];
  int          m_hits   = 0;
  int          m_misses = 0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 8) % 256);
  endfunction

  function automatic logic [31:0] blk_of(input logic [31:0] a);
    return a - (a % 8);
  endfunction

  task automatic get_block(input logic [31:0] blk, output logic [63:0] d);
    if (!mem.exists(int'(blk))) mem[int'(blk)] = {$urandom, $urandom};
    d = mem[int'(blk)];
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] d, input logic [31:0] a);
    return ((a % 8) >= 4) ? d[63:32] : d[31:0];
  endfunction

`ifdef ICACHE_STATS_EN
  task automatic check_stats(input string tag);
    check({tag, "_hits"},   64'(hit_cnt),  64'(m_hits));
    check({tag, "_misses"}, 64'(miss_cnt), 64'(m_misses));
  endtask
`endif

  // One complete lookup: hit or miss+refill after lat cycles, optional stall while missing.
  task automatic fetch(input logic [31:0] addr, input int lat, input int stall);
    logic [63:0] d;
    logic [31:0] w;
    bit          hit;
    int          idx;
    idx = idx_of(addr);
    hit = resident.exists(idx) && (resident[idx] == blk_of(addr));
    get_block(blk_of(addr), d);
    w = word_of(d, addr);
    @(negedge Sys_clk);
    bus.IFIC_en   = 1'b1;
    bus.IFIC_addr = addr;
    @(negedge Sys_clk);
    if (hit) begin
      m_hits++;
      check("hit_en",     64'(bus.ICIF_en),   64'd1);
      check("hit_inst",   64'(bus.ICIF_inst), 64'(w));
      check("hit_no_req", 64'(bus.ICMC_en),   64'd0);
    end else begin
      m_misses++;
      check("miss_no_resp", 64'(bus.ICIF_en),   64'd0);
      check("miss_req",     64'(bus.ICMC_en),   64'd1);
      check("miss_addr",    64'(bus.ICMC_addr), 64'(blk_of(addr)));
      if (stall > 0) begin
        Sys_rdy = 1'b0;
        repeat (stall) begin
          @(negedge Sys_clk);
          check("stall_req",     64'(bus.ICMC_en),   64'd1);
          check("stall_addr",    64'(bus.ICMC_addr), 64'(blk_of(addr)));
          check("stall_no_resp", 64'(bus.ICIF_en),   64'd0);
        end
        Sys_rdy = 1'b1;
      end
      repeat (lat) @(negedge Sys_clk);
      check("wait_req", 64'(bus.ICMC_en), 64'd1);
      bus.MCIC_en    = 1'b1;
      bus.MCIC_block = d;
      @(negedge Sys_clk);
      bus.MCIC_en = 1'b0;
      resident[idx] = blk_of(addr);
      check("fill_resp",     64'(bus.ICIF_en),   64'd1);
      check("fill_inst",     64'(bus.ICIF_inst), 64'(w));
      check("fill_req_drop", 64'(bus.ICMC_en),   64'd0);
      check("fill_addr_clr", 64'(bus.ICMC_addr), 64'd0);
    end
    bus.IFIC_en = 1'b0;
    @(negedge Sys_clk);
    check("resp_pulse", 64'(bus.ICIF_en), 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    logic [31:0] a;
    bus.IFIC_en    = 1'b0;
    bus.IFIC_addr  = '0;
    bus.MCIC_en    = 1'b0;
    bus.MCIC_block = '0;
    mem[32'h1000]  = 64'h22222222_11111111;

    repeat (3) @(negedge Sys_clk);
    check("rst_icif_en",   64'(bus.ICIF_en),   64'd0);
    check("rst_icif_inst", 64'(bus.ICIF_inst), 64'd0);
    check("rst_icmc_en",   64'(bus.ICMC_en),   64'd0);
    check("rst_icmc_addr", 64'(bus.ICMC_addr), 64'd0);
    Sys_rst_n = 1'b1;

    // Cold miss, hit on the other word, then a conflicting tag at index 0.
    fetch(32'h0000_1004, 2, 0);
    fetch(32'h0000_1000, 0, 0);
    fetch(32'h0000_1800, 1, 0);
    fetch(32'h0000_1000, 0, 0);
`ifdef ICACHE_STATS_EN
    check_stats("conflict");
`endif

    fetch(32'h0000_2008, 1, 5);

    // Abort by dropping IFIC_en: refill installs, no response.
    get_block(32'h10, d);
    @(negedge Sys_clk);
    bus.IFIC_en   = 1'b1;
    bus.IFIC_addr = 32'h10;
    @(negedge Sys_clk);
    m_misses++;
    check("abort_req", 64'(bus.ICMC_en), 64'd1);
    bus.IFIC_en = 1'b0;
    repeat (2) @(negedge Sys_clk);
    bus.MCIC_en    = 1'b1;
    bus.MCIC_block = d;
    @(negedge Sys_clk);
    bus.MCIC_en = 1'b0;
    resident[idx_of(32'h10)] = 32'h10;
    check("abort_no_resp", 64'(bus.ICIF_en), 64'd0);
    check("abort_req_clr", 64'(bus.ICMC_en), 64'd0);
    @(negedge Sys_clk);
    check("abort_quiet",   64'(bus.ICIF_en), 64'd0);
    fetch(32'h0000_0014, 0, 0);

    // Abort by changing the address within the block: next lookup hits from IDLE.
    get_block(32'h20, d);
    @(negedge Sys_clk);
    bus.IFIC_en   = 1'b1;
    bus.IFIC_addr = 32'h20;
    @(negedge Sys_clk);
    m_misses++;
    bus.IFIC_addr  = 32'h24;
    bus.MCIC_en    = 1'b1;
    bus.MCIC_block = d;
    @(negedge Sys_clk);
    bus.MCIC_en = 1'b0;
    resident[idx_of(32'h20)] = 32'h20;
    check("chg_no_resp", 64'(bus.ICIF_en), 64'd0);
    @(negedge Sys_clk);
    m_hits++;
    check("chg_hit_en",   64'(bus.ICIF_en),   64'd1);
    check("chg_hit_inst", 64'(bus.ICIF_inst), 64'(d[63:32]));
    bus.IFIC_en = 1'b0;
    @(negedge Sys_clk);

    // Reset in the middle of a miss, then a late refill pulse.
    @(negedge Sys_clk);
    bus.IFIC_en   = 1'b1;
    bus.IFIC_addr = 32'h4000;
    @(negedge Sys_clk);
    check("rst_pre_req", 64'(bus.ICMC_en), 64'd1);
    #2 Sys_rst_n = 1'b0;
    #1;
    check("rst_mid_req",  64'(bus.ICMC_en),   64'd0);
    check("rst_mid_addr", 64'(bus.ICMC_addr), 64'd0);
    check("rst_mid_resp", 64'(bus.ICIF_en),   64'd0);
    bus.IFIC_en = 1'b0;
    @(negedge Sys_clk);
    Sys_rst_n      = 1'b1;
    bus.MCIC_en    = 1'b1;
    bus.MCIC_block = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge Sys_clk);
    bus.MCIC_en = 1'b0;
    check("late_mcic_resp", 64'(bus.ICIF_en), 64'd0);
    check("late_mcic_req",  64'(bus.ICMC_en), 64'd0);
    resident.delete();
    m_hits   = 0;
    m_misses = 0;
`ifdef ICACHE_STATS_EN
    check_stats("after_reset");
`endif
    fetch(32'h0000_0014, 0, 0);

    // Random traffic over a few tags and indices to mix hits and conflicts.
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 3) << 11) | ($urandom_range(0, 3) << 3) | ($urandom_range(0, 1) << 2);
      fetch(a, $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
    end
`ifdef ICACHE_STATS_EN
    check_stats("final");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
